load_store_unit: RTL



---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sub-word load/store front end for a 128 x 32-bit data memory
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses return resp_err instead of clearing low bits.
module load_store_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [8:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [6:0]  mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_we2,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [8:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] merge_q, merge_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        illegal;
   logic        misaligned;
   logic        sign_ext;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;
   logic [31:0] merged;

   always_comb begin
      illegal = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11) || (we_q && funct3_q[2]);
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
      misaligned = 1'b0;
`endif
      sign_ext = ~funct3_q[2];
      case (addr_q[1:0])
         2'd0:    byte_sel = mem_read_data[7:0];
         2'd1:    byte_sel = mem_read_data[15:8];
         2'd2:    byte_sel = mem_read_data[23:16];
         default: byte_sel = mem_read_data[31:24];
      endcase
      half_sel = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
      case (funct3_q[1:0])
         2'b00:   load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
         2'b01:   load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
         default: load_data = mem_read_data;
      endcase
   end

   // Lane replacement for the read-modify-write; only B and H stores reach WRITE.
   always_comb begin
      merged = merge_q;
      if (funct3_q[0]) begin
         if (addr_q[1]) merged[31:16] = wdata_q[15:0];
         else           merged[15:0]  = wdata_q[15:0];
      end else begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end
   end

   always_comb begin
      state_d        = state_q;
      we_d           = we_q;
      funct3_d       = funct3_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      merge_d        = merge_q;
      rdata_d        = rdata_q;
      err_d          = err_q;
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      mem_address    = 7'd0;
      mem_write_data = 32'd0;
      mem_we2        = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               rdata_d  = 32'd0;
               err_d    = 1'b0;
               state_d  = S_ACCESS;
            end
         end
         S_ACCESS: begin
            mem_address = addr_q[8:2];
            if (illegal || misaligned) begin
               mem_address = 7'd0;
               err_d       = 1'b1;
               state_d     = S_RESP;
            end else if (!we_q) begin
               rdata_d = load_data;
               state_d = S_RESP;
            end else if (funct3_q[1:0] == 2'b10) begin
               mem_write_data = wdata_q;
               mem_we2        = 1'b1;
               state_d        = S_RESP;
            end else begin
               merge_d = mem_read_data;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            mem_address    = addr_q[8:2];
            mem_write_data = merged;
            mem_we2        = 1'b1;
            state_d        = S_RESP;
         end
         default: begin
            resp_valid = 1'b1;
            state_d    = S_IDLE;
         end
      endcase
      // Reset silences every output in the same cycle, even before the state register clears.
      if (reset) begin
         req_ready      = 1'b0;
         resp_valid     = 1'b0;
         mem_address    = 7'd0;
         mem_write_data = 32'd0;
         mem_we2        = 1'b0;
      end
   end

   assign resp_rdata = reset ? 32'd0 : rdata_q;
   assign resp_err   = reset ? 1'b0 : err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= 9'd0;
         wdata_q  <= 32'd0;
         merge_q  <= 32'd0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         merge_q  <= merge_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

endmodule
